// File: rtl/axi_burst_ram_pkg.sv
// Shared types for the AXI burst RAM: FSM state encodings and the per-burst
// bookkeeping record used by both the write and the read channel.
`ifndef AXI_ID_LEN
`define AXI_ID_LEN 4
`endif

package axi_ram_pkg;

  // Widest transaction ID and word index the burst record can carry.
  localparam int ID_MAX_W  = 16;
  localparam int IDX_MAX_W = 32;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} AxiWrState_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} AxiRdState_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0]  id;
    logic [IDX_MAX_W-1:0] index;
    logic [7:0]           len;
    logic [7:0]           cnt;
  } AxiBurst_t;

endpackage

// File: rtl/axi_burst_ram_if.sv
// AXI4 write/read channel bundle between the SoC master port and the RAM.
`ifndef AXI_ID_LEN
`define AXI_ID_LEN 4
`endif

interface axi_burst_ram_if #(
  parameter int WIDTH    = 128,
  parameter int ADDR_LEN = 32,
  parameter int ID_LEN   = `AXI_ID_LEN
);
  logic [ID_LEN-1:0]    s_axi_awid;
  logic [ADDR_LEN-1:0]  s_axi_awaddr;
  logic [7:0]           s_axi_awlen;
  logic [2:0]           s_axi_awsize;
  logic [1:0]           s_axi_awburst;
  logic                 s_axi_awlock;
  logic [3:0]           s_axi_awcache;
  logic                 s_axi_awvalid;
  logic                 s_axi_awready;
  logic [WIDTH-1:0]     s_axi_wdata;
  logic [WIDTH/8-1:0]   s_axi_wstrb;
  logic                 s_axi_wlast;
  logic                 s_axi_wvalid;
  logic                 s_axi_wready;
  logic                 s_axi_bready;
  logic [ID_LEN-1:0]    s_axi_bid;
  logic                 s_axi_bvalid;
  logic [ID_LEN-1:0]    s_axi_arid;
  logic [ADDR_LEN-1:0]  s_axi_araddr;
  logic [7:0]           s_axi_arlen;
  logic [2:0]           s_axi_arsize;
  logic [1:0]           s_axi_arburst;
  logic                 s_axi_arlock;
  logic [3:0]           s_axi_arcache;
  logic                 s_axi_arvalid;
  logic                 s_axi_arready;
  logic                 s_axi_rready;
  logic [ID_LEN-1:0]    s_axi_rid;
  logic [WIDTH-1:0]     s_axi_rdata;
  logic                 s_axi_rlast;
  logic                 s_axi_rvalid;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awcache, s_axi_awvalid,
           s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
           s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arlock, s_axi_arcache, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bvalid,
           s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rlast, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
           s_axi_awlock, s_axi_awcache, s_axi_awvalid,
           s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
           s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arlock, s_axi_arcache, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bvalid,
           s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi_burst_ram_mem.sv
// Byte-masked word array: one synchronous write port, one asynchronous read
// port. A read and a write to the same word in one cycle returns old data.
module axi_burst_ram_mem #(
  parameter int WIDTH   = 128,
  parameter int DEPTH_W = 16
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [DEPTH_W-1:0]   waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [WIDTH/8-1:0]   wstrb_i,
  input  logic [DEPTH_W-1:0]   raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_W];

  // Update only the byte lanes whose strobe bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave RAM with independent write and read burst FSMs. Every burst is
// treated as full-width INCR; size/burst/lock/cache are ignored.
// Optional macro AXI_RAM_RDELAY_EN adds an R_WAIT state so the first read beat
// appears READ_DELAY cycles after AR accept instead of one.
`ifndef AXI_ID_LEN
`define AXI_ID_LEN 4
`endif

module axi_burst_ram
  import axi_ram_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int ADDR_LEN   = 32,
  parameter int ID_LEN     = `AXI_ID_LEN,
  parameter int MEM_SIZE_E = 20,
  parameter int READ_DELAY = 4
) (
  input logic             clk,
  input logic             rst,
  axi_burst_ram_if.slave  s_axi
);
  localparam int OFF   = $clog2(WIDTH/8);
  localparam int IDX_W = MEM_SIZE_E - OFF;

  AxiWrState_t            wst_q, wst_d;
  AxiRdState_t            rst_q, rst_d;
  AxiBurst_t              wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_raddr;
  logic [WIDTH-1:0]       mem_rdata;
  logic [IDX_MAX_W-1:0]   ar_idx, rd_next_idx;
  logic                   rlast;
`ifdef AXI_RAM_RDELAY_EN
  logic [7:0]             dly_q, dly_d;
`endif

  function automatic logic [IDX_MAX_W-1:0] addr_to_index(input logic [ADDR_LEN-1:0] a);
    return IDX_MAX_W'(a[MEM_SIZE_E-1:OFF]);
  endfunction

  axi_burst_ram_mem #(.WIDTH(WIDTH), .DEPTH_W(IDX_W)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_q.index[IDX_W-1:0]),
    .wdata_i (s_axi.s_axi_wdata),
    .wstrb_i (s_axi.s_axi_wstrb),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Write channel: accept AW, absorb beats until wlast or len reached, respond on B.
  always_comb begin
    wst_d  = wst_q;
    wr_d   = wr_q;
    mem_we = 1'b0;
    case (wst_q)
      W_IDLE: if (s_axi.s_axi_awvalid) begin
        wr_d.id    = ID_MAX_W'(s_axi.s_axi_awid);
        wr_d.index = addr_to_index(s_axi.s_axi_awaddr);
        wr_d.len   = s_axi.s_axi_awlen;
        wr_d.cnt   = 8'd0;
        wst_d      = W_DATA;
      end
      W_DATA: if (s_axi.s_axi_wvalid) begin
        mem_we     = 1'b1;
        wr_d.index = wr_q.index + IDX_MAX_W'(1);
        wr_d.cnt   = wr_q.cnt + 8'd1;
        if (s_axi.s_axi_wlast || (wr_q.cnt == wr_q.len)) wst_d = W_RESP;
      end
      W_RESP: if (s_axi.s_axi_bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // Write-channel state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q <= W_IDLE;
      wr_q  <= '0;
    end else begin
      wst_q <= wst_d;
      wr_q  <= wr_d;
    end
  end

  assign ar_idx      = addr_to_index(s_axi.s_axi_araddr);
  assign rd_next_idx = rd_q.index + IDX_MAX_W'(1);
  assign rlast       = (rst_q == R_DATA) && (rd_q.cnt == rd_q.len);

  // Read channel: preload the next word on every accepted beat so beats stream without bubbles.
  always_comb begin
    rst_d     = rst_q;
    rd_d      = rd_q;
    rdata_d   = rdata_q;
    mem_raddr = rd_next_idx[IDX_W-1:0];
`ifdef AXI_RAM_RDELAY_EN
    dly_d     = dly_q;
`endif
    case (rst_q)
      R_IDLE: begin
        mem_raddr = ar_idx[IDX_W-1:0];
        if (s_axi.s_axi_arvalid) begin
          rd_d.id    = ID_MAX_W'(s_axi.s_axi_arid);
          rd_d.index = ar_idx;
          rd_d.len   = s_axi.s_axi_arlen;
          rd_d.cnt   = 8'd0;
`ifdef AXI_RAM_RDELAY_EN
          dly_d      = 8'(READ_DELAY - 1);
          if (READ_DELAY > 1) begin
            rst_d = R_WAIT;
          end else begin
            rdata_d = mem_rdata;
            rst_d   = R_DATA;
          end
`else
          rdata_d    = mem_rdata;
          rst_d      = R_DATA;
`endif
        end
      end
`ifdef AXI_RAM_RDELAY_EN
      R_WAIT: begin
        mem_raddr = rd_q.index[IDX_W-1:0];
        dly_d     = dly_q - 8'd1;
        if (dly_q <= 8'd1) begin
          rdata_d = mem_rdata;
          rst_d   = R_DATA;
        end
      end
`endif
      R_DATA: if (s_axi.s_axi_rready) begin
        if (rlast) begin
          rst_d = R_IDLE;
        end else begin
          rdata_d    = mem_rdata;
          rd_d.index = rd_next_idx;
          rd_d.cnt   = rd_q.cnt + 8'd1;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  // Read-channel state and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q   <= R_IDLE;
      rd_q    <= '0;
      rdata_q <= '0;
`ifdef AXI_RAM_RDELAY_EN
      dly_q   <= 8'd0;
`endif
    end else begin
      rst_q   <= rst_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
`ifdef AXI_RAM_RDELAY_EN
      dly_q   <= dly_d;
`endif
    end
  end

  assign s_axi.s_axi_awready = (wst_q == W_IDLE);
  assign s_axi.s_axi_wready  = (wst_q == W_DATA);
  assign s_axi.s_axi_bvalid  = (wst_q == W_RESP);
  assign s_axi.s_axi_bid     = wr_q.id[ID_LEN-1:0];
  assign s_axi.s_axi_arready = (rst_q == R_IDLE);
  assign s_axi.s_axi_rvalid  = (rst_q == R_DATA);
  assign s_axi.s_axi_rlast   = rlast;
  assign s_axi.s_axi_rid     = rd_q.id[ID_LEN-1:0];
  assign s_axi.s_axi_rdata   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.s_axi_awsize, s_axi.s_axi_awburst, s_axi.s_axi_awlock,
                       s_axi.s_axi_awcache, s_axi.s_axi_arsize, s_axi.s_axi_arburst,
                       s_axi.s_axi_arlock, s_axi.s_axi_arcache, s_axi.s_axi_awaddr,
                       s_axi.s_axi_araddr, wr_q.id, rd_q.id, wr_q.index, rd_q.index,
                       rd_next_idx, ar_idx};
endmodule
